// File: rtl/seq_alu_md.sv
// Registered ALU with an iterative unsigned multiply/divide unit.
// Single-cycle ops complete at accept; mul/div take WIDTH iterations behind busy.
module seq_alu_md #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_isdiv;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;

  logic [WIDTH-1:0] r_y, r_hi;
  logic             r_done, r_zero, r_carry, r_ovf, r_dz;

  logic             w_accept, w_is_md, w_last;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_sc_y, w_sc_hi;
  logic             w_sc_c, w_sc_ov, w_sc_dz;

  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_dsub;
  logic [WIDTH-1:0] w_it_acc, w_it_q;

  assign w_accept = start && (r_state == S_IDLE);
  assign w_is_md  = (op == 4'b1000) || ((op == 4'b1001) && (b != '0));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_md) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sum   = {1'b0, a} + {1'b0, b};
    w_diff  = {1'b0, a} - {1'b0, b};
    w_sc_y  = '0;
    w_sc_hi = '0;
    w_sc_c  = 1'b0;
    w_sc_ov = 1'b0;
    w_sc_dz = 1'b0;
    if (!op[3]) begin
      case (op[2:0])
        3'b000: w_sc_y = a & b;
        3'b001: w_sc_y = a | b;
        3'b010: begin
          w_sc_y  = w_sum[WIDTH-1:0];
          w_sc_c  = w_sum[WIDTH];
          w_sc_ov = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ w_sum[WIDTH-1]);
        end
        3'b100: w_sc_y = a ^ b;
        3'b101: w_sc_y = ~(a | b);
        3'b110: begin
          w_sc_y  = w_diff[WIDTH-1:0];
          w_sc_c  = w_diff[WIDTH];
          w_sc_ov = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ w_diff[WIDTH-1]);
        end
        3'b111: begin
          w_sc_y  = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1]};
          w_sc_c  = w_diff[WIDTH];
          w_sc_ov = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ w_diff[WIDTH-1]);
        end
        default: w_sc_y = '0;
      endcase
    end else if ((op == 4'b1001) && (b == '0)) begin
      w_sc_y  = '1;
      w_sc_hi = a;
      w_sc_dz = 1'b1;
    end
  end

  // One iteration step: mul shifts {acc,q} right after a conditional add;
  // div shifts {acc,q} left and restores when the trial subtract would borrow.
  always_comb begin
    w_madd   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    w_shift  = {r_acc, r_q[WIDTH-1]};
    w_dsub   = w_shift[WIDTH-1:0] - r_m;
    w_it_acc = w_madd[WIDTH:1];
    w_it_q   = {w_madd[0], r_q[WIDTH-1:1]};
    if (r_isdiv) begin
      if (w_shift >= {1'b0, r_m}) begin
        w_it_acc = w_dsub;
        w_it_q   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_it_acc = w_shift[WIDTH-1:0];
        w_it_q   = {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_isdiv <= 1'b0;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_y     <= '0;
      r_hi    <= '0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          if (w_is_md) begin
            r_isdiv <= op[0];
            r_m     <= b;
            r_acc   <= '0;
            r_q     <= a;
            r_cnt   <= '0;
          end else begin
            r_y     <= w_sc_y;
            r_hi    <= w_sc_hi;
            r_zero  <= (w_sc_y == '0);
            r_carry <= w_sc_c;
            r_ovf   <= w_sc_ov;
            r_dz    <= w_sc_dz;
            r_done  <= 1'b1;
          end
        end
      end else begin
        r_acc <= w_it_acc;
        r_q   <= w_it_q;
        if (w_last) begin
          r_cnt   <= '0;
          r_y     <= w_it_q;
          r_hi    <= w_it_acc;
          r_zero  <= (w_it_q == '0);
          r_carry <= 1'b0;
          r_ovf   <= !r_isdiv && (w_it_acc != '0);
          r_dz    <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign y        = r_y;
  assign hi       = r_hi;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign overflow = r_ovf;
  assign divzero  = r_dz;

endmodule

// File: tb/tb_seq_alu_md.sv
// Self-checking bench for seq_alu_md: directed test-plan steps plus random ops
// checked against an arithmetic reference model.
module tb_seq_alu_md;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, carry, overflow, divzero;
  logic [W-1:0] y, hi;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] last_y = '0;

  seq_alu_md #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .hi(hi), .zero(zero), .carry(carry),
    .overflow(overflow), .divzero(divzero)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] f, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       output logic [W-1:0] ey, output logic [W-1:0] ehi,
                       output logic ez, output logic ec, output logic eov,
                       output logic edz, output logic emd);
    logic [W:0]     s, d;
    logic [2*W-1:0] p;
    s = {1'b0, xa} + {1'b0, xb};
    d = {1'b0, xa} - {1'b0, xb};
    ey = '0; ehi = '0; ec = 1'b0; eov = 1'b0; edz = 1'b0; emd = 1'b0;
    if (f[3] == 1'b0) begin
      case (f[2:0])
        3'd0: ey = xa & xb;
        3'd1: ey = xa | xb;
        3'd2: begin
          ey = s[W-1:0]; ec = s[W];
          eov = (xa[W-1] == xb[W-1]) && (s[W-1] != xa[W-1]);
        end
        3'd4: ey = xa ^ xb;
        3'd5: ey = ~(xa | xb);
        3'd6, 3'd7: begin
          ey = (f[0]) ? W'(d[W-1]) : d[W-1:0];
          ec = d[W];
          eov = (xa[W-1] != xb[W-1]) && (d[W-1] != xa[W-1]);
        end
        default: ey = '0;
      endcase
    end else if (f == 4'd8) begin
      p = {{W{1'b0}}, xa} * {{W{1'b0}}, xb};
      ey = p[W-1:0]; ehi = p[2*W-1:W]; eov = (ehi != 0); emd = 1'b1;
    end else if (f == 4'd9) begin
      if (xb == 0) begin
        ey = '1; ehi = xa; edz = 1'b1;
      end else begin
        ey = xa / xb; ehi = xa % xb; emd = 1'b1;
      end
    end
    ez = (ey == 0);
  endtask

  task automatic chk_res(input string s, input logic [W-1:0] ey, input logic [W-1:0] ehi,
                         input logic ez, input logic ec, input logic eov, input logic edz);
    chk({s, ".done"}, 32'(done), 32'(1));
    chk({s, ".y"}, 32'(y), 32'(ey));
    chk({s, ".hi"}, 32'(hi), 32'(ehi));
    chk({s, ".zero"}, 32'(zero), 32'(ez));
    chk({s, ".carry"}, 32'(carry), 32'(ec));
    chk({s, ".ovf"}, 32'(overflow), 32'(eov));
    chk({s, ".divzero"}, 32'(divzero), 32'(edz));
  endtask

  task automatic issue(input logic [3:0] f, input logic [W-1:0] xa, input logic [W-1:0] xb);
    @(negedge clk);
    start = 1'b1; op = f; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic run_op(input string s, input logic [3:0] f, input logic [W-1:0] xa,
                        input logic [W-1:0] xb);
    logic [W-1:0] ey, ehi;
    logic ez, ec, eov, edz, emd;
    int cyc;
    model(f, xa, xb, ey, ehi, ez, ec, eov, edz, emd);
    issue(f, xa, xb);
    if (emd) begin
      cyc = 0;
      while (busy === 1'b1 && cyc < 3 * W) begin
        chk({s, ".hold_y"}, 32'(y), 32'(last_y));
        @(posedge clk); #1;
        cyc++;
      end
      chk({s, ".busy_len"}, 32'(cyc), 32'(W));
    end else begin
      chk({s, ".no_busy"}, 32'(busy), 32'(0));
    end
    chk_res(s, ey, ehi, ez, ec, eov, edz);
    last_y = ey;
  endtask

  initial begin
    logic [W-1:0] ey, ehi, cy, chi;
    logic ez, ec, eov, edz, emd, cov;
    int pulses, busyseen;
    logic [3:0] rf;
    logic [W-1:0] ra, rb;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    chk("rst.outs", {y, hi}, 32'(0));
    chk("rst.flags", 32'({zero, carry, overflow, divzero}), 32'(0));
    reset = 1'b0;

    run_op("add_ovf", 4'b0010, 16'h7FFF, 16'h0001);
    run_op("sub_eq", 4'b0110, 16'h0005, 16'h0005);
    run_op("mul1", 4'b1000, 16'h1234, 16'h0100);
    run_op("mul_max", 4'b1000, 16'hFFFF, 16'hFFFF);
    @(posedge clk); #1;
    chk("mul_max.done_once", 32'(done), 32'(0));
    run_op("div", 4'b1001, 16'd100, 16'd7);
    run_op("div0", 4'b1001, 16'h1234, 16'h0000);

    // start with an add in the middle of a multiply must be ignored
    model(4'b1000, 16'h00AB, 16'h0CDE, ey, ehi, ez, ec, eov, edz, emd);
    issue(4'b1000, 16'h00AB, 16'h0CDE);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; cy = '0; chi = '0; cov = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        pulses++; cy = y; chi = hi; cov = overflow;
      end
      @(posedge clk); #1;
    end
    chk("ignore.pulses", 32'(pulses), 32'(1));
    chk("ignore.y", 32'(cy), 32'(ey));
    chk("ignore.hi", 32'(chi), 32'(ehi));
    chk("ignore.ovf", 32'(cov), 32'(eov));
    chk("ignore.busy", 32'(busy), 32'(0));
    last_y = ey;

    // reset during a divide aborts it with no done pulse
    issue(4'b1001, 16'd1000, 16'd3);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.busy", 32'(busy), 32'(0));
    chk("abort.done", 32'(done), 32'(0));
    chk("abort.outs", {y, hi}, 32'(0));
    chk("abort.flags", 32'({zero, carry, overflow, divzero}), 32'(0));
    pulses = 0; busyseen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) busyseen++;
      @(posedge clk); #1;
    end
    chk("abort.no_done", 32'(pulses), 32'(0));
    chk("abort.no_busy", 32'(busyseen), 32'(0));
    last_y = '0;
    run_op("post_abort_add", 4'b0010, 16'h1111, 16'h2222);

    run_op("slt", 4'b0111, 16'hFFFF, 16'h0001);
    run_op("b2b_mul", 4'b1000, 16'h0300, 16'h0007);
    run_op("b2b_slt", 4'b0111, 16'h0002, 16'h0009);
    @(posedge clk); #1;
    chk("b2b.done_end", 32'(done), 32'(0));

    for (int i = 0; i < 40; i++) begin
      rf = 4'($urandom_range(0, 15));
      if (i % 8 == 0) rf = 4'd9;
      if (i % 8 == 1) rf = 4'd8;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
      run_op("rand", rf, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_alu_md.md
Name: seq_alu_md

Overview:
- Registered, parametrised ALU with an iterative unsigned multiply/divide unit and a start/busy/done handshake.
- Logic ops, add, sub and slt complete in one cycle.
- Multiply and divide use a WIDTH-iteration shift-add / restoring-division datapath and write a HI/LO result pair.
- Sits in the processor execute stage; the controller stalls on busy.

Parameters:
- WIDTH, 16, operand/result width (must be >= 4).
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where busy=0.
- op  input  4  operation select, sampled at accept.
- a  input  WIDTH  operand A, sampled at accept.
- b  input  WIDTH  operand B, sampled at accept.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse: results valid.
- y  output  WIDTH  primary result (LO for mul/div).
- hi  output  WIDTH  upper product / remainder; 0 for single-cycle ops.
- zero  output  1  y == 0.
- carry  output  1  carry/borrow out (add, sub, slt only).
- overflow  output  1  signed overflow (add/sub/slt); product overflow (mul).
- divzero  output  1  set by divide with b==0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: busy, done, y, hi, zero, carry, overflow and divzero all 0; state IDLE; counter 0. Reset wins over start and aborts any in-flight operation with no done pulse.
- op[3]=0, single-cycle ALU, f=op[2:0]:
  - 000 and; 001 or; 010 add; 100 xor; 101 nor; 110 sub (a-b); 111 slt; 011 gives y=0.
  - Sum and difference are computed WIDTH+1 bits wide. carry = bit WIDTH of the sum/difference.
  - add overflow = (a[MSB] XNOR b[MSB]) & (a[MSB] XOR sum[MSB]).
  - sub/slt overflow = (a[MSB] XOR b[MSB]) & (a[MSB] XOR diff[MSB]).
  - slt y = {0..., diff[WIDTH-1]}.
  - Other ops: carry=overflow=0.
- op=1000, multu: {hi,y} = a*b, unsigned, 2*WIDTH bits. overflow = (hi != 0); carry = 0.
- op=1001, divu: y = a/b, hi = a%b, unsigned. carry = overflow = 0.
- op=101x, 11xx (reserved): treated as single-cycle, all results 0.
- divzero is 0 for every op except divide by zero.
- zero = (y == 0) for every op; hi is ignored.
- Handshake and latency:
  - Accept edge E0 = rising edge with start=1, busy=0, reset=0.
  - Single-cycle ops: outputs register at E0; done=1 in the cycle after E0; busy stays 0.
  - mul/div with b!=0: state RUN; busy=1 for the WIDTH cycles after E0, with one iteration per edge E1..E(WIDTH). At E(WIDTH), results register, busy drops and done=1 for exactly one cycle.
  - divu with b==0: single-cycle path; y = all ones, hi = a, divzero=1.
- States: IDLE -> RUN on accepted mul/div; RUN -> IDLE when counter reaches WIDTH-1 at an edge. No other transitions except reset.
- start while busy=1: ignored, not queued; operands in flight unchanged.
- Back-to-back: a start in the done cycle (busy=0) is accepted. done may therefore stay high on consecutive cycles, each cycle for a different result.
- Outputs y, hi and flags hold their last values between done pulses and change only at result edges. Intermediate iteration state never appears on the outputs.
- a and b may change freely after E0; internal copies are used.

Test Plan (WIDTH=16):
- Add 0x7FFF + 0x0001 -> next cycle: done=1, y=0x8000, overflow=1, carry=0, zero=0, hi=0. Then sub 0x0005 - 0x0005 -> y=0, zero=1, carry=0.
- multu 0x1234 * 0x0100 -> busy=1 for 16 cycles, then one-cycle done with hi=0x0012, y=0x3400, overflow=1. Then 0xFFFF * 0xFFFF -> hi=0xFFFE, y=0x0001.
- divu 100 / 7 -> done after 16 busy cycles, y=14, hi=2, divzero=0. divu 0x1234 / 0 -> next cycle: y=0xFFFF, hi=0x1234, divzero=1, busy never 1.
- Start multu, then pulse start with an add at busy cycle 5 -> add ignored; final results are the product only, with exactly one done pulse.
- Start divu, assert reset at busy cycle 8 -> next cycle all outputs 0, busy=0, and no done pulse follows. A new add then works normally.
- slt 0xFFFF, 0x0001 -> y=1. Then issue slt in the same cycle a multu done is high -> slt accepted, done high two consecutive cycles with the correct y each cycle.
